// File: rtl/fre_div_sel.sv
// fre_div_sel: selectable clock-enable divider driven by a one-hot ratio select.
// Produces a registered square wave (div_out) and a last-cycle-of-period strobe (div_pulse).
// Ratio changes and stops are deferred to the next period boundary so no phase is truncated.
// Optional macro FDIV_IMMEDIATE_SWITCH_EN: apply ratio changes and stops on the next cycle,
// truncating the running period.
module fre_div_sel #(
  parameter int unsigned DIV0  = 2,
  parameter int unsigned DIV1  = 4,
  parameter int unsigned DIV2  = 10,
  parameter int unsigned DIV3  = 100,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_choose,
  output logic       div_out,
  output logic       div_pulse,
  output logic [1:0] sel_idx,
  output logic       active
);

  // Terminal count (N-1) and high-phase length (floor(N/2)); both fit in CNT_W bits.
  localparam logic [CNT_W-1:0] Lim0  = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] Lim1  = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] Lim2  = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] Lim3  = CNT_W'(DIV3 - 1);
  localparam logic [CNT_W-1:0] Half0 = CNT_W'(DIV0 / 2);
  localparam logic [CNT_W-1:0] Half1 = CNT_W'(DIV1 / 2);
  localparam logic [CNT_W-1:0] Half2 = CNT_W'(DIV2 / 2);
  localparam logic [CNT_W-1:0] Half3 = CNT_W'(DIV3 / 2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             div_out_q, div_out_d;
  logic             div_pulse_q, div_pulse_d;
  logic             oh_valid;
  logic [1:0]       oh_idx;
  logic             boundary;

`ifndef FDIV_IMMEDIATE_SWITCH_EN
  // Deferred request: either a new ratio index or a stop.
  logic             pend_q, pend_d;
  logic             pend_stop_q, pend_stop_d;
  logic [1:0]       pend_idx_q, pend_idx_d;
`endif

  function automatic logic [CNT_W-1:0] lim_of(input logic [1:0] idx);
    unique case (idx)
      2'd0: lim_of = Lim0;
      2'd1: lim_of = Lim1;
      2'd2: lim_of = Lim2;
      2'd3: lim_of = Lim3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_of(input logic [1:0] idx);
    unique case (idx)
      2'd0: half_of = Half0;
      2'd1: half_of = Half1;
      2'd2: half_of = Half2;
      2'd3: half_of = Half3;
    endcase
  endfunction

  // Decode the one-hot select; zero and multi-hot values decode as not valid.
  always_comb begin
    oh_valid = 1'b0;
    oh_idx   = 2'd0;
    unique case (key_choose)
      4'b0001: begin oh_valid = 1'b1; oh_idx = 2'd0; end
      4'b0010: begin oh_valid = 1'b1; oh_idx = 2'd1; end
      4'b0100: begin oh_valid = 1'b1; oh_idx = 2'd2; end
      4'b1000: begin oh_valid = 1'b1; oh_idx = 2'd3; end
      default: ;
    endcase
  end

  assign boundary = (cnt_q == lim_of(sel_q));

  // Next-state logic for the IDLE/RUN machine, period counter and ratio selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
`ifndef FDIV_IMMEDIATE_SWITCH_EN
    pend_d      = pend_q;
    pend_stop_d = pend_stop_q;
    pend_idx_d  = pend_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (oh_valid) begin
          state_d = StRun;
          cnt_d   = '0;
          sel_d   = oh_idx;
        end
      end
      StRun: begin
`ifdef FDIV_IMMEDIATE_SWITCH_EN
        if (key_choose == 4'b0000) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (oh_valid && (oh_idx != sel_q)) begin
          cnt_d = '0;
          sel_d = oh_idx;
        end else if (boundary) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        // Fold this cycle's request in first so a boundary-cycle request applies at once.
        if (key_choose == 4'b0000) begin
          pend_d      = 1'b1;
          pend_stop_d = 1'b1;
        end else if (oh_valid && (oh_idx != sel_q)) begin
          pend_d      = 1'b1;
          pend_stop_d = 1'b0;
          pend_idx_d  = oh_idx;
        end
        if (boundary) begin
          cnt_d = '0;
          if (pend_d) begin
            if (pend_stop_d) state_d = StIdle;
            else             sel_d   = pend_idx_d;
            pend_d      = 1'b0;
            pend_stop_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next count so they register in step with cnt_q.
  always_comb begin
    div_out_d   = (state_d == StRun) && (cnt_d < half_of(sel_d));
    div_pulse_d = (state_d == StRun) && (cnt_d == lim_of(sel_d));
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      div_out_q   <= 1'b0;
      div_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      div_out_q   <= div_out_d;
      div_pulse_q <= div_pulse_d;
    end
  end

`ifndef FDIV_IMMEDIATE_SWITCH_EN
  // Pending-request register; reset discards any deferred request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_stop_q <= 1'b0;
      pend_idx_q  <= 2'd0;
    end else begin
      pend_q      <= pend_d;
      pend_stop_q <= pend_stop_d;
      pend_idx_q  <= pend_idx_d;
    end
  end
`endif

  assign div_out   = div_out_q;
  assign div_pulse = div_pulse_q;
  assign sel_idx   = sel_q;
  assign active    = (state_q == StRun);

endmodule

// File: tb/tb_fre_div_sel.sv
// Scoreboard bench for fre_div_sel: the stimulus process pushes the expected outputs for the
// cycle after each edge; a monitor pops and compares one entry per clock.
module tb_fre_div_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_choose = 4'b0000;
  logic       div_out;
  logic       div_pulse;
  logic [1:0] sel_idx;
  logic       active;

  fre_div_sel #(
    .DIV0 (2),
    .DIV1 (4),
    .DIV2 (10),
    .DIV3 (100),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_choose(key_choose),
    .div_out   (div_out),
    .div_pulse (div_pulse),
    .sel_idx   (sel_idx),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Expected {div_out, div_pulse, sel_idx[1:0], active}
  logic [4:0] exp_q[$];
  int         id_q[$];
  int         seq      = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  // Monitor: compare one expected entry per cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    int         id;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      id = id_q.pop_front();
      a = {div_out, div_pulse, sel_idx, active};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs#%0d got out=%b pulse=%b sel=%0d act=%b want out=%b pulse=%b sel=%0d act=%b",
                    id, a[4], a[3], a[2:1], a[0], e[4], e[3], e[2:1], e[0]);
    end
  end

  // Drive one cycle of input and queue what the DUT must show after the next edge.
  task automatic drive(input logic [3:0] k, input logic r, input logic [4:0] e);
    @(negedge clk);
    key_choose = k;
    rst        = r;
    exp_q.push_back(e);
    id_q.push_back(seq);
    seq++;
  endtask

  // Running expectations: count c walks start, start+1, ... modulo n.
  task automatic run(input logic [3:0] k, input logic [1:0] s, input int n, input int half,
                     input int start, input int count);
    for (int i = 0; i < count; i++) begin
      int c;
      c = (start + i) % n;
      drive(k, 1'b0, {(c < half), (c == n - 1), s, 1'b1});
    end
  endtask

  task automatic idle(input logic [3:0] k, input logic [1:0] s, input int count);
    for (int i = 0; i < count; i++) drive(k, 1'b0, {2'b00, s, 1'b0});
  endtask

  initial begin
    // Reset, then no selection for 50 cycles.
    drive(4'b0000, 1'b1, 5'b0);
    drive(4'b0000, 1'b1, 5'b0);
    idle(4'b0000, 2'd0, 50);

    // DIV1=4: 1,1,0,0 with strobe on the last cycle.
    run(4'b0010, 2'd1, 4, 2, 0, 12);

    // Multi-hot is ignored; period and index unchanged.
    run(4'b0011, 2'd1, 4, 2, 0, 6);
    run(4'b0010, 2'd1, 4, 2, 2, 2);

    // Request sampled on the boundary cycle switches to DIV2=10 at that boundary.
    run(4'b0100, 2'd2, 10, 5, 0, 4);

    // Switch to DIV0 at cnt=3.
`ifdef FDIV_IMMEDIATE_SWITCH_EN
    run(4'b0001, 2'd0, 2, 1, 0, 12);
`else
    run(4'b0001, 2'd2, 10, 5, 4, 6);
    run(4'b0001, 2'd0, 2, 1, 0, 6);
`endif

    // DIV3=100, then requests 0 then 2 before the boundary; only index 2 appears.
    run(4'b1000, 2'd3, 100, 50, 0, 3);
`ifdef FDIV_IMMEDIATE_SWITCH_EN
    run(4'b0001, 2'd0, 2, 1, 0, 2);
    run(4'b0100, 2'd2, 10, 5, 0, 105);
`else
    run(4'b0001, 2'd3, 100, 50, 3, 2);
    run(4'b0100, 2'd3, 100, 50, 5, 95);
    run(4'b0100, 2'd2, 10, 5, 0, 10);
`endif

    // DIV3 up to cnt=50 with a pending request, then reset discards everything.
    run(4'b1000, 2'd3, 100, 50, 0, 50);
`ifdef FDIV_IMMEDIATE_SWITCH_EN
    run(4'b1000, 2'd3, 100, 50, 50, 1);
`else
    run(4'b0010, 2'd3, 100, 50, 50, 1);
`endif
    drive(4'b0010, 1'b1, 5'b0);
    idle(4'b0000, 2'd0, 5);

    // Stop request: finishes the current period, then idles with sel_idx kept.
    run(4'b0100, 2'd2, 10, 5, 0, 3);
`ifndef FDIV_IMMEDIATE_SWITCH_EN
    run(4'b0000, 2'd2, 10, 5, 3, 7);
`endif
    idle(4'b0000, 2'd2, 4);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain got %0d pending entries want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fre_div_sel.md
# fre_div_sel

Selectable clock-enable divider that consumes the one-hot `key_choose` selection produced by the key front end and generates a divided square wave plus a once-per-period strobe. It holds the output idle until the first selection arrives. Ratio changes take effect glitch-free on the next period boundary, so downstream stages never see a truncated high or low phase.

## Interface
- `DIV0`, default 2: divide ratio selected by `key_choose == 4'b0001`; must be ≥ 2.
- `DIV1`, default 4: ratio for `4'b0010`; must be ≥ 2.
- `DIV2`, default 10: ratio for `4'b0100`; must be ≥ 2.
- `DIV3`, default 100: ratio for `4'b1000`; must be ≥ 2.
- `CNT_W`, default 16: period counter width; every `DIVx` must be ≤ 2^CNT_W.

Ports:
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key_choose` input 4: one-hot ratio select from the key stage; `4'b0000` means no selection.
- `div_out` output 1: divided square wave, registered.
- `div_pulse` output 1: one-cycle strobe in the last cycle of every period, registered.
- `sel_idx` output 2: index (0–3) of the ratio currently in effect.
- `active` output 1: high while in RUN.

## Operation
- Reset values: `div_out=0`, `div_pulse=0`, `sel_idx=0`, `active=0`, counter `cnt=0`, pending flag cleared, state IDLE.
- Input decode:
  - A valid one-hot value maps to index 0–3.
  - Any other non-zero value (multi-hot) is ignored; the previous request is kept.
- State machine with two states, IDLE and RUN.
- IDLE → RUN:
  - Triggered when a valid one-hot value is sampled.
  - Next cycle: `cnt=0`, `sel_idx` = decoded index, `active=1`.
- RUN, period generation:
  - With `N = DIV[sel_idx]`, `cnt` counts 0 … N−1 and then wraps to 0.
  - `div_out=1` while `cnt < N/2` (floor) and 0 otherwise. Example: N=3 gives 1 cycle high, 2 cycles low.
  - `div_pulse=1` exactly when `cnt == N−1`.
- RUN, ratio change:
  - A sampled one-hot value whose index differs from `sel_idx` is latched into a pending register. An index equal to `sel_idx` has no effect.
  - A newer request overwrites the pending one (latest wins).
  - When `cnt == N−1` and a request is pending: next cycle `cnt=0`, `sel_idx` = pending index, pending cleared.
  - A request sampled in the boundary cycle itself is applied at that same boundary.
- RUN → IDLE:
  - If `key_choose == 0` is sampled, the stop is treated as pending.
  - At the next boundary: state IDLE, `active=0`, `div_out=0`, `cnt=0`, `sel_idx` unchanged.
- Arithmetic:
  - `cnt` is unsigned `CNT_W` bits.
  - The compare against N−1 uses `CNT_W`-bit constants, so there is no overflow as long as `DIVx ≤ 2^CNT_W`.

## Timing
- Selection sampled in cycle t → `active=1`, `div_out=1`, `cnt=0` in cycle t+1.
- Steady state:
  - `div_out` period is exactly N cycles.
  - `div_pulse` rises every N cycles, coincident with the last low cycle of `div_out`.
- Ratio change pending at boundary cycle b: cycle b+1 starts the new period at `cnt=0`, and `div_out` goes high.
- `rst` asserted mid-period: all outputs take their reset values on the next edge; the pending request is discarded.
- `rst` wins over every other event in the same cycle.

## Configuration
- `FDIV_IMMEDIATE_SWITCH_EN` defined:
  - No pending register.
  - A differing valid selection sampled in cycle t restarts the counter: cycle t+1 has `cnt=0`, the new `sel_idx`, and `div_out=1`.
  - `key_choose == 0` returns to IDLE at t+1.
  - The current period may be truncated.
- Not defined (default): boundary-aligned switching, as described under Operation.

## Test plan
- Reset, then `key_choose=0` for 50 cycles → `div_out=0`, `div_pulse=0`, `active=0`, `sel_idx=0` throughout.
- `key_choose=4'b0010` (DIV1=4) → from the next cycle `div_out` repeats 1,1,0,0; `div_pulse` is high on every 4th cycle; `active=1`; `sel_idx=1`.
- Running DIV2=10, switch to `4'b0001` at `cnt=3` → remaining 6 cycles of the 10-cycle period complete unchanged, then `div_out` toggles every cycle with `sel_idx=0`. With the macro defined, the toggling starts at the next cycle instead.
- Running DIV3=100, requests `4'b0001` then `4'b0100` before the boundary → only `sel_idx=2` appears after the boundary, never 0.
- Multi-hot `4'b0011` while running DIV1 → no change in period or `sel_idx`.
- `rst` pulse at `cnt=50` of DIV3 → next cycle all outputs are 0 and state is IDLE; the pending request is lost.
